// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (seq/branch/jump/jr)
// and the IF/ID pipeline register, with a sticky misaligned-fetch fault.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RUN   | normal fetch; PC advances to npc unless stalled
// ST_FAULT | misaligned npc seen; PC frozen, D fed nops until reset
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        branch_taken,
  input  logic [31:0] jr_target,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc8_D,
  output logic [15:0] imm16_D,
  output logic        valid_D,
  output logic        fault
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FAULT = 1'b1;

  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_JMP = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic [31:0] seq_pc;
  logic [31:0] br_pc;
  logic [31:0] jmp_pc;
  logic [31:0] br_offset;
  logic [31:0] npc;
  logic        npc_misaligned;

  always_comb begin
    seq_pc    = pc_f_q + 32'd4;
    br_offset = {{14{ifid_instr_q[15]}}, ifid_instr_q[15:0], 2'b00};
    br_pc     = ifid_pc_q + 32'd4 + br_offset;
    jmp_pc    = {ifid_pc_q[31:28], ifid_instr_q[25:0], 2'b00};
    npc       = seq_pc;
    case (npc_sel)
      NPC_BR:  if (branch_taken) npc = br_pc;
      NPC_JMP: npc = jmp_pc;
      NPC_JR:  npc = jr_target;
      default: npc = seq_pc;
    endcase
    npc_misaligned = (npc[1:0] != 2'b00);
  end

  always_comb begin
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    case (state_q)
      ST_RUN: begin
        if (!stall) begin
          if (npc_misaligned) begin
            // The bad target is never fetched; the detecting edge already injects the bubble.
            state_d      = ST_FAULT;
            ifid_instr_d = 32'h0;
            ifid_valid_d = 1'b0;
          end else begin
            pc_f_d       = npc;
            ifid_instr_d = im_rdata;
            ifid_pc_d    = pc_f_q;
            ifid_valid_d = 1'b1;
          end
        end
      end
      default: begin
        ifid_instr_d = 32'h0;
        ifid_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      pc_f_q       <= PC_RESET;
      ifid_instr_q <= 32'h0;
      ifid_pc_q    <= 32'h0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign im_addr = pc_f_q;
  assign instr_D = ifid_instr_q;
  assign pc_D    = ifid_pc_q;
  assign pc8_D   = ifid_pc_q + 32'd8;
  assign imm16_D = ifid_instr_q[15:0];
  assign valid_D = ifid_valid_q;
  assign fault   = (state_q == ST_FAULT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, branch, jump, stalled jr,
// misaligned-fetch fault with async reset recovery, and PC wrap.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        branch_taken;
  logic [31:0] jr_target;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic [31:0] pc8_D;
  logic [15:0] imm16_D;
  logic        valid_D;
  logic        fault;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP_ADDI = 32'h2408_0001;
  localparam logic [31:0] BEQ_M4   = 32'h1000_FFFC;
  localparam logic [31:0] J_3040   = 32'h0800_0C10;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .npc_sel      (npc_sel),
    .branch_taken (branch_taken),
    .jr_target    (jr_target),
    .im_addr      (im_addr),
    .im_rdata     (im_rdata),
    .instr_D      (instr_D),
    .pc_D         (pc_D),
    .pc8_D        (pc8_D),
    .imm16_D      (imm16_D),
    .valid_D      (valid_D),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    stall        = 1'b0;
    npc_sel      = 2'd0;
    branch_taken = 1'b0;
    jr_target    = 32'h0;
    im_rdata     = NOP_ADDI;
    #2;
    check("rst_im_addr", im_addr, 32'h3000);
    check("rst_instr_D", instr_D, 32'h0);
    check("rst_pc_D",    pc_D,    32'h0);
    check("rst_valid_D", {31'b0, valid_D}, 32'h0);
    check("rst_fault",   {31'b0, fault},   32'h0);
    check("rst_pc8_D",   pc8_D,   32'h8);
    check("rst_imm16_D", {16'b0, imm16_D}, 32'h0);
    #1 reset = 1'b0;

    // Free-running sequential fetch
    step();
    check("seq1_im_addr", im_addr, 32'h3004);
    check("seq1_pc_D",    pc_D,    32'h3000);
    check("seq1_valid_D", {31'b0, valid_D}, 32'h1);
    check("seq1_instr_D", instr_D, NOP_ADDI);
    check("seq1_pc8_D",   pc8_D,   32'h3008);
    check("seq1_imm16_D", {16'b0, imm16_D}, 32'h0001);
    step();
    check("seq2_im_addr", im_addr, 32'h3008);
    check("seq2_pc_D",    pc_D,    32'h3004);
    step();
    check("seq3_im_addr", im_addr, 32'h300C);
    check("seq3_pc_D",    pc_D,    32'h3008);
    step();
    check("seq4_im_addr", im_addr, 32'h3010);

    // Taken beq at 0x3010, offset -4 words -> 0x3004
    im_rdata = BEQ_M4;
    step();
    check("beq_pc_D",    pc_D,    32'h3010);
    check("beq_imm16_D", {16'b0, imm16_D}, 32'h0000FFFC);
    im_rdata     = NOP_ADDI;
    npc_sel      = 2'd1;
    branch_taken = 1'b1;
    step();
    check("bt_im_addr", im_addr, 32'h3004);
    check("bt_slot_pc_D", pc_D, 32'h3014);
    npc_sel      = 2'd0;
    branch_taken = 1'b0;
    step();
    step();
    step();
    check("walk_im_addr", im_addr, 32'h3010);

    // Not-taken beq falls through past the delay slot
    im_rdata = BEQ_M4;
    step();
    check("beq2_pc_D", pc_D, 32'h3010);
    im_rdata     = NOP_ADDI;
    npc_sel      = 2'd1;
    branch_taken = 1'b0;
    step();
    check("bnt_im_addr", im_addr, 32'h3018);
    check("bnt_pc_D",    pc_D,    32'h3014);
    npc_sel = 2'd0;
    step();
    step();
    check("pre_j_im_addr", im_addr, 32'h3020);

    // j at 0x3020 -> 0x3040
    im_rdata = J_3040;
    step();
    check("j_instr_D", instr_D, J_3040);
    check("j_pc_D",    pc_D,    32'h3020);
    im_rdata = NOP_ADDI;
    npc_sel  = 2'd2;
    step();
    check("j_im_addr", im_addr, 32'h3040);
    check("j_slot_pc_D", pc_D, 32'h3024);

    // jr held by a 2-cycle stall, then released
    npc_sel   = 2'd3;
    stall     = 1'b1;
    jr_target = 32'h3100;
    step();
    check("stall1_im_addr", im_addr, 32'h3040);
    check("stall1_pc_D",    pc_D,    32'h3024);
    step();
    check("stall2_im_addr", im_addr, 32'h3040);
    check("stall2_pc_D",    pc_D,    32'h3024);
    check("stall2_instr_D", instr_D, NOP_ADDI);
    stall = 1'b0;
    step();
    check("jr_im_addr", im_addr, 32'h3100);
    check("jr_pc_D",    pc_D,    32'h3040);

    // Misaligned jr target -> sticky fault
    jr_target = 32'h3102;
    step();
    check("flt_fault",   {31'b0, fault},   32'h1);
    check("flt_im_addr", im_addr, 32'h3100);
    check("flt_instr_D", instr_D, 32'h0);
    check("flt_valid_D", {31'b0, valid_D}, 32'h0);
    check("flt_pc_D",    pc_D,    32'h3040);
    stall     = 1'b1;
    jr_target = 32'h3200;
    step();
    check("flt2_fault",   {31'b0, fault}, 32'h1);
    check("flt2_im_addr", im_addr, 32'h3100);
    check("flt2_instr_D", instr_D, 32'h0);

    // Async reset between edges clears fault immediately
    #2 reset = 1'b1;
    #1;
    check("arst_fault",   {31'b0, fault}, 32'h0);
    check("arst_im_addr", im_addr, 32'h3000);
    check("arst_pc_D",    pc_D,    32'h0);
    #1 reset = 1'b0;
    stall     = 1'b0;

    // PC wrap via jr to the top word
    npc_sel   = 2'd3;
    jr_target = 32'hFFFF_FFFC;
    step();
    check("wrap_jr_im_addr", im_addr, 32'hFFFF_FFFC);
    check("wrap_jr_pc_D",    pc_D,    32'h3000);
    npc_sel = 2'd0;
    step();
    check("wrap_im_addr", im_addr, 32'h0000_0000);
    check("wrap_fault",   {31'b0, fault}, 32'h0);
    check("wrap_pc_D",    pc_D,    32'hFFFF_FFFC);
    check("wrap_pc8_D",   pc8_D,   32'h0000_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
